// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, instruction field positions, class enum and decoded bundle.
package decode_pkg;

   localparam int REG_AW = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int OPC_LSB   = 26;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_LSB = 6;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_LSB   = 0;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_I_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_ILLEGAL
   } instr_class_e;

   typedef struct packed {
      logic [5:0]        opcode;
      logic [5:0]        funct;
      logic [4:0]        shamt;
      logic [31:0]       imm;
      logic [REG_AW-1:0] dest;
      logic              we;
      logic              illegal;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
   } id_bundle_t;

   function automatic instr_class_e classify(input logic [5:0] op);
      instr_class_e cls;
      case (op)
         OP_RTYPE:                                        cls = CLS_R;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: cls = CLS_I_ALU;
         OP_LW:                                           cls = CLS_LOAD;
         OP_SW:                                           cls = CLS_STORE;
         OP_BEQ, OP_BNE:                                  cls = CLS_BRANCH;
         OP_J:                                            cls = CLS_JUMP;
         default:                                         cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Build option DECODE_WB_BYPASS_EN hides a register from the hazard check in its writeback cycle.
module decode_scoreboard
   import decode_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [ADDR_WIDTH-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [ADDR_WIDTH-1:0] clr_addr,
   input  logic                  chk_a_en,
   input  logic [ADDR_WIDTH-1:0] chk_a_addr,
   input  logic                  chk_b_en,
   input  logic [ADDR_WIDTH-1:0] chk_b_addr,
   output logic                  hazard_a,
   output logic                  hazard_b
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] visible;

   // Register 0 is hardwired, so it is never tracked.
   assign set_mask[0] = 1'b0;
   assign clr_mask[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi = gi + 1) begin : g_mask
         assign set_mask[gi] = set_en && (set_addr == ADDR_WIDTH'(gi));
         assign clr_mask[gi] = clr_en && (clr_addr == ADDR_WIDTH'(gi));
      end
   endgenerate

   always_comb begin
      pending_d = (pending_q & ~clr_mask) | set_mask;
   end

`ifdef DECODE_WB_BYPASS_EN
   assign visible = pending_q & ~clr_mask;
`else
   assign visible = pending_q;
`endif

   assign hazard_a = chk_a_en && visible[chk_a_addr];
   assign hazard_b = chk_b_en && visible[chk_b_addr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: splits fetched words into fields, drives register bank read addresses,
// and stalls on read-after-write hazards. Build option: DECODE_WB_BYPASS_EN (see decode_scoreboard).
module decode_stage
   import decode_pkg::*;
#(
   parameter int ADDR_WIDTH  = 5,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   if_valid,
   input  logic [INSTR_WIDTH-1:0] if_instr,
   output logic                   if_ready,
   output logic [ADDR_WIDTH-1:0]  addra,
   output logic [ADDR_WIDTH-1:0]  addrb,
   output logic                   id_valid,
   input  logic                   ex_ready,
   output logic [5:0]             id_opcode,
   output logic [5:0]             id_funct,
   output logic [4:0]             id_shamt,
   output logic [31:0]            id_imm,
   output logic [ADDR_WIDTH-1:0]  id_dest,
   output logic                   id_we,
   output logic                   id_illegal,
   input  logic                   wb_en,
   input  logic [ADDR_WIDTH-1:0]  wb_addr
);

   instr_class_e      cls;
   logic [5:0]        if_opcode;
   logic [REG_AW-1:0] if_rs;
   logic [REG_AW-1:0] if_rt;
   logic [REG_AW-1:0] if_rd;
   logic [REG_AW-1:0] if_dest;
   logic              reads_rs;
   logic              reads_rt;
   logic              writes;
   logic              hazard_a;
   logic              hazard_b;
   logic              out_free;
   logic              accept;

   logic              id_valid_q;
   logic              id_valid_d;
   id_bundle_t        bundle_q;
   id_bundle_t        bundle_d;

   assign if_opcode = if_instr[OPC_LSB +: 6];
   assign if_rs     = if_instr[RS_LSB +: REG_AW];
   assign if_rt     = if_instr[RT_LSB +: REG_AW];
   assign if_rd     = if_instr[RD_LSB +: REG_AW];
   assign cls       = classify(if_opcode);

   always_comb begin
      reads_rs = 1'b0;
      reads_rt = 1'b0;
      if_dest  = '0;
      case (cls)
         CLS_R: begin
            reads_rs = 1'b1;
            reads_rt = 1'b1;
            if_dest  = if_rd;
         end
         CLS_I_ALU, CLS_LOAD: begin
            reads_rs = 1'b1;
            if_dest  = if_rt;
         end
         CLS_STORE, CLS_BRANCH: begin
            reads_rs = 1'b1;
            reads_rt = 1'b1;
         end
         default: ;
      endcase
      writes = (if_dest != '0);
   end

   decode_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sb (
      .clock      (clock),
      .reset      (reset),
      .set_en     (accept && writes),
      .set_addr   (if_dest),
      .clr_en     (wb_en),
      .clr_addr   (wb_addr),
      .chk_a_en   (reads_rs),
      .chk_a_addr (if_rs),
      .chk_b_en   (reads_rt),
      .chk_b_addr (if_rt),
      .hazard_a   (hazard_a),
      .hazard_b   (hazard_b)
   );

   assign out_free = !id_valid_q || ex_ready;
   assign if_ready = out_free && !hazard_a && !hazard_b;
   assign accept   = if_valid && if_ready;

   always_comb begin
      id_valid_d = id_valid_q;
      bundle_d   = bundle_q;
      if (accept) begin
         id_valid_d       = 1'b1;
         bundle_d.opcode  = if_opcode;
         bundle_d.funct   = if_instr[FUNCT_LSB +: 6];
         bundle_d.shamt   = if_instr[SHAMT_LSB +: 5];
         bundle_d.imm     = {{16{if_instr[IMM_LSB + 15]}}, if_instr[IMM_LSB +: 16]};
         bundle_d.dest    = if_dest;
         bundle_d.we      = writes;
         bundle_d.illegal = (cls == CLS_ILLEGAL);
         bundle_d.rs      = if_rs;
         bundle_d.rt      = if_rt;
      end else if (out_free) begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         id_valid_q <= 1'b0;
         bundle_q   <= '0;
      end else begin
         id_valid_q <= id_valid_d;
         bundle_q   <= bundle_d;
      end
   end

   // The bank registers its read, so on accept it must see the incoming addresses;
   // otherwise the held ones keep dataa/datab matched to the stalled bundle.
   assign addra = accept ? if_rs : bundle_q.rs;
   assign addrb = accept ? if_rt : bundle_q.rt;

   assign id_valid   = id_valid_q;
   assign id_opcode  = bundle_q.opcode;
   assign id_funct   = bundle_q.funct;
   assign id_shamt   = bundle_q.shamt;
   assign id_imm     = bundle_q.imm;
   assign id_dest    = bundle_q.dest;
   assign id_we      = bundle_q.we;
   assign id_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a reference model.
module tb_decode_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        if_ready;
   logic [4:0]  addra;
   logic [4:0]  addrb;
   logic        id_valid;
   logic        ex_ready;
   logic [5:0]  id_opcode;
   logic [5:0]  id_funct;
   logic [4:0]  id_shamt;
   logic [31:0] id_imm;
   logic [4:0]  id_dest;
   logic        id_we;
   logic        id_illegal;
   logic        wb_en;
   logic [4:0]  wb_addr;

   always #5 clock = ~clock;

   decode_stage dut (
      .clock      (clock),
      .reset      (reset),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_ready   (if_ready),
      .addra      (addra),
      .addrb      (addrb),
      .id_valid   (id_valid),
      .ex_ready   (ex_ready),
      .id_opcode  (id_opcode),
      .id_funct   (id_funct),
      .id_shamt   (id_shamt),
      .id_imm     (id_imm),
      .id_dest    (id_dest),
      .id_we      (id_we),
      .id_illegal (id_illegal),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr)
   );

   localparam bit [31:0] I_ADD    = 32'h00221820; // add  $3,$1,$2
   localparam bit [31:0] I_SUB    = 32'h00612022; // sub  $4,$3,$1
   localparam bit [31:0] I_ADDI0  = 32'h20200005; // addi $0,$1,5
   localparam bit [31:0] I_ADD600 = 32'h00003020; // add  $6,$0,$0
   localparam bit [31:0] I_LW     = 32'h8C45FFFC; // lw   $5,-4($2)
   localparam bit [31:0] I_ADDI1  = 32'h20410007; // addi $1,$2,7
   localparam bit [31:0] I_ADDI7  = 32'h20270001; // addi $7,$1,1
   localparam bit [31:0] I_ADD877 = 32'h00E74020; // add  $8,$7,$7
   localparam bit [31:0] I_ILL    = 32'hFC221820; // opcode 0x3F

`ifdef DECODE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      bit        reads_rs;
      bit        reads_rt;
      bit        writes_class;
      bit        we;
      bit        illegal;
      bit [4:0]  dest;
      bit [5:0]  opcode;
      bit [5:0]  funct;
      bit [4:0]  shamt;
      bit [31:0] imm;
   } ref_t;

   int        n_vec = 0;
   int        n_err = 0;

   bit [31:0] m_pend;
   bit        m_valid;
   ref_t      m_b;
   bit [4:0]  m_rs;
   bit [4:0]  m_rt;

   bit        obs_ready, exp_ready;
   bit [4:0]  obs_addra, exp_addra, obs_addrb, exp_addrb;

   function automatic ref_t ref_decode(input bit [31:0] w);
      ref_t r;
      int   op;
      int   s;
      r = '{default: 0};
      op = int'(w[31:26]);
      s = $signed(w[15:0]);
      r.opcode = w[31:26];
      r.funct  = w[5:0];
      r.shamt  = w[10:6];
      r.imm    = s;
      if (op == 0) begin
         r.reads_rs = 1; r.reads_rt = 1; r.writes_class = 1; r.dest = w[15:11];
      end else if (op inside {8, 9, 10, 12, 13, 15, 35}) begin
         r.reads_rs = 1; r.writes_class = 1; r.dest = w[20:16];
      end else if (op inside {43, 4, 5}) begin
         r.reads_rs = 1; r.reads_rt = 1;
      end else if (op != 2) begin
         r.illegal = 1;
      end
      r.we = r.writes_class && (r.dest != 0);
      return r;
   endfunction

   task automatic model_reset();
      m_pend  = '0;
      m_valid = 0;
      m_b     = '{default: 0};
      m_rs    = '0;
      m_rt    = '0;
   endtask

   // One clock: drive at the falling edge, capture combinational outputs, update the model after the rising edge.
   task automatic step(input bit v, input bit [31:0] ins, input bit exr, input bit wen, input bit [4:0] wa);
      ref_t      d;
      bit [31:0] eff;
      bit        free;
      bit        acc;
      @(negedge clock);
      if_valid = v; if_instr = ins; ex_ready = exr; wb_en = wen; wb_addr = wa;
      #1;
      d   = ref_decode(ins);
      eff = m_pend;
      if (BYP && wen && wa != 0) eff[wa] = 0;
      free      = !m_valid || exr;
      exp_ready = free && !((d.reads_rs && eff[ins[25:21]]) || (d.reads_rt && eff[ins[20:16]]));
      acc       = v && exp_ready;
      exp_addra = acc ? ins[25:21] : m_rs;
      exp_addrb = acc ? ins[20:16] : m_rt;
      obs_ready = if_ready;
      obs_addra = addra;
      obs_addrb = addrb;
      @(posedge clock);
      #1;
      if (wen && wa != 0) m_pend[wa] = 0;
      if (acc) begin
         m_b     = d;
         m_rs    = ins[25:21];
         m_rt    = ins[20:16];
         m_valid = 1;
         if (d.we) m_pend[d.dest] = 1;
         $display("txn t=%0t instr=%08h accepted", $time, ins);
      end else if (free) begin
         m_valid = 0;
      end
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 0; if_valid = 0; if_instr = '0; ex_ready = 0; wb_en = 0; wb_addr = '0;
      repeat (2) @(negedge clock);
      reset = 1;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 0; if_valid = 0; if_instr = '0; ex_ready = 0; wb_en = 0; wb_addr = '0;
      repeat (2) @(negedge clock);
      #1;
      n_vec++;
      if ({id_valid, id_opcode, id_funct, id_shamt, id_imm, id_dest, id_we, id_illegal} !== '0) begin
         n_err++; $display("FAIL reset_outputs: got valid=%0b op=%h imm=%h dest=%0d, want all 0", id_valid, id_opcode, id_imm, id_dest);
      end
      n_vec++;
      if ({addra, addrb} !== 10'd0) begin
         n_err++; $display("FAIL reset_addr: got addra=%0d addrb=%0d, want 0 0", addra, addrb);
      end
      n_vec++;
      if (dut.u_sb.pending_q !== 32'd0) begin
         n_err++; $display("FAIL reset_pending: got %h, want 0", dut.u_sb.pending_q);
      end
      n_vec++;
      if (if_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_if_ready: got %0b, want 1", if_ready);
      end
      @(negedge clock);
      reset = 1;
      model_reset();
   endtask

   task automatic test_rtype();
      apply_reset();
      step(1, I_ADD, 1, 0, 0);
      n_vec++;
      if ({obs_ready, obs_addra, obs_addrb} !== {1'b1, 5'd1, 5'd2}) begin
         n_err++; $display("FAIL rtype_issue: got ready=%0b a=%0d b=%0d, want 1 1 2", obs_ready, obs_addra, obs_addrb);
      end
      n_vec++;
      if ({id_valid, id_dest, id_we, id_illegal, id_funct} !== {1'b1, 5'd3, 1'b1, 1'b0, 6'h20}) begin
         n_err++; $display("FAIL rtype_bundle: got v=%0b dest=%0d we=%0b ill=%0b f=%h, want 1 3 1 0 20", id_valid, id_dest, id_we, id_illegal, id_funct);
      end
      n_vec++;
      if (dut.u_sb.pending_q[3] !== 1'b1 || addra !== 5'd1) begin
         n_err++; $display("FAIL rtype_pending: got pend3=%0b addra=%0d, want 1 1", dut.u_sb.pending_q[3], addra);
      end
      step(0, '0, 1, 0, 0);
   endtask

   task automatic test_raw_hazard();
      apply_reset();
      step(1, I_ADD, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(1, I_SUB, 1, 0, 0);
         n_vec++;
         if (obs_ready !== 1'b0) begin
            n_err++; $display("FAIL hazard_stall%0d: got if_ready=%0b, want 0", i, obs_ready);
         end
      end
      step(1, I_SUB, 1, 1, 3);
      n_vec++;
      if (obs_ready !== BYP) begin
         n_err++; $display("FAIL hazard_wb_cycle: got if_ready=%0b, want %0b", obs_ready, BYP);
      end
      n_vec++;
      if (id_valid !== BYP) begin
         n_err++; $display("FAIL hazard_wb_issue: got id_valid=%0b, want %0b", id_valid, BYP);
      end
      step(1, I_SUB, 1, 0, 0);
      n_vec++;
      if ({obs_ready, id_valid, id_dest} !== {1'b1, 1'b1, 5'd4}) begin
         n_err++; $display("FAIL hazard_release: got ready=%0b v=%0b dest=%0d, want 1 1 4", obs_ready, id_valid, id_dest);
      end
      n_vec++;
      if (dut.u_sb.pending_q[4:3] !== 2'b10) begin
         n_err++; $display("FAIL hazard_pending: got pend[4:3]=%b, want 10", dut.u_sb.pending_q[4:3]);
      end
      step(0, '0, 1, 0, 0);
   endtask

   task automatic test_dest_zero();
      apply_reset();
      step(1, I_ADDI0, 1, 0, 0);
      n_vec++;
      if ({id_valid, id_we} !== 2'b10 || dut.u_sb.pending_q !== 32'd0) begin
         n_err++; $display("FAIL dest0_bundle: got v=%0b we=%0b pend=%h, want 1 0 0", id_valid, id_we, dut.u_sb.pending_q);
      end
      step(1, I_ADD600, 1, 0, 0);
      n_vec++;
      if (obs_ready !== 1'b1) begin
         n_err++; $display("FAIL dest0_no_stall: got if_ready=%0b, want 1", obs_ready);
      end
      step(0, '0, 1, 0, 0);
   endtask

   task automatic test_stall_hold();
      apply_reset();
      step(1, I_LW, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, I_ADD, 0, 0, 0);
         n_vec++;
         if ({obs_ready, obs_addra} !== {1'b0, 5'd2}) begin
            n_err++; $display("FAIL hold_ready%0d: got ready=%0b addra=%0d, want 0 2", i, obs_ready, obs_addra);
         end
         n_vec++;
         if ({id_valid, id_imm, id_dest, id_opcode} !== {1'b1, 32'hFFFFFFFC, 5'd5, 6'h23}) begin
            n_err++; $display("FAIL hold_bundle%0d: got v=%0b imm=%h dest=%0d op=%h, want 1 fffffffc 5 23", i, id_valid, id_imm, id_dest, id_opcode);
         end
      end
      step(1, I_ADD, 1, 0, 0);
      n_vec++;
      if ({obs_ready, id_dest, id_opcode} !== {1'b1, 5'd3, 6'h00}) begin
         n_err++; $display("FAIL hold_release: got ready=%0b dest=%0d op=%h, want 1 3 00", obs_ready, id_dest, id_opcode);
      end
      step(0, '0, 1, 0, 0);
   endtask

   task automatic test_illegal();
      apply_reset();
      step(1, I_ADDI1, 1, 0, 0);
      step(1, I_ILL, 1, 0, 0);
      n_vec++;
      if (obs_ready !== 1'b1) begin
         n_err++; $display("FAIL illegal_no_stall: got if_ready=%0b, want 1", obs_ready);
      end
      n_vec++;
      if ({id_valid, id_illegal, id_we} !== 3'b110) begin
         n_err++; $display("FAIL illegal_bundle: got v=%0b ill=%0b we=%0b, want 1 1 0", id_valid, id_illegal, id_we);
      end
      n_vec++;
      if (dut.u_sb.pending_q[3:1] !== 3'b001) begin
         n_err++; $display("FAIL illegal_pending: got pend[3:1]=%b, want 001", dut.u_sb.pending_q[3:1]);
      end
      step(0, '0, 1, 0, 0);
   endtask

   task automatic test_reset_mid_stall();
      apply_reset();
      step(1, I_ADDI7, 1, 0, 0);
      step(1, I_ADD877, 0, 0, 0);
      n_vec++;
      if ({id_valid, dut.u_sb.pending_q[7], obs_ready} !== 3'b110) begin
         n_err++; $display("FAIL midrst_setup: got v=%0b pend7=%0b ready=%0b, want 1 1 0", id_valid, dut.u_sb.pending_q[7], obs_ready);
      end
      #2;
      reset = 0;
      if_valid = 0;
      #1;
      n_vec++;
      if ({id_valid, addra, addrb} !== 11'd0 || dut.u_sb.pending_q !== 32'd0) begin
         n_err++; $display("FAIL midrst_clear: got v=%0b a=%0d b=%0d pend=%h, want 0 0 0 0", id_valid, addra, addrb, dut.u_sb.pending_q);
      end
      @(negedge clock);
      reset = 1;
      model_reset();
      if_valid = 1;
      #1;
      n_vec++;
      if (if_ready !== 1'b1) begin
         n_err++; $display("FAIL midrst_release: got if_ready=%0b, want 1", if_ready);
      end
      step(0, '0, 1, 0, 0);
   endtask

   task automatic test_random();
      bit [5:0]  ops [13];
      bit [31:0] w;
      int        k;
      ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h00};
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         w = $urandom;
         k = $urandom_range(0, 12);
         w[31:26] = (k == 12) ? 6'($urandom_range(0, 63)) : ops[k];
         w[25:21] = 5'($urandom_range(0, 7));
         w[20:16] = 5'($urandom_range(0, 7));
         w[15:11] = 5'($urandom_range(0, 7));
         step(($urandom % 4) != 0, w, ($urandom % 4) != 0, ($urandom % 3) == 0, 5'($urandom_range(0, 7)));
         n_vec++;
         if ({obs_ready, obs_addra, obs_addrb} !== {exp_ready, exp_addra, exp_addrb}) begin
            n_err++; $display("FAIL rand_comb c=%0d: got ready=%0b a=%0d b=%0d, want %0b %0d %0d", c, obs_ready, obs_addra, obs_addrb, exp_ready, exp_addra, exp_addrb);
         end
         n_vec++;
         if (id_valid !== m_valid || dut.u_sb.pending_q !== m_pend) begin
            n_err++; $display("FAIL rand_state c=%0d: got v=%0b pend=%h, want %0b %h", c, id_valid, dut.u_sb.pending_q, m_valid, m_pend);
         end
         if (m_valid) begin
            n_vec++;
            if ({id_opcode, id_funct, id_shamt, id_imm, id_we, id_illegal} !==
                {m_b.opcode, m_b.funct, m_b.shamt, m_b.imm, m_b.we, m_b.illegal} ||
                (m_b.writes_class && id_dest !== m_b.dest)) begin
               n_err++; $display("FAIL rand_bundle c=%0d: got op=%h f=%h sh=%0d imm=%h d=%0d we=%0b ill=%0b, want %h %h %0d %h %0d %0b %0b",
                                 c, id_opcode, id_funct, id_shamt, id_imm, id_dest, id_we, id_illegal,
                                 m_b.opcode, m_b.funct, m_b.shamt, m_b.imm, m_b.dest, m_b.we, m_b.illegal);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_rtype();
      test_raw_hazard();
      test_dest_zero();
      test_stall_hold();
      test_illegal();
      test_reset_mid_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
